// File: rtl/sdp_ram_be.sv
// sdp_ram_be: single-clock simple dual-port RAM with byte enables, collision mode and a hardware clear sequencer
module sdp_ram_be #(
  parameter int SIZE = 8,
  parameter int DEPTH = 8,
  parameter int BYTE_W = 8,
  parameter int RD_MODE = 0,
  parameter logic [SIZE-1:0] CLEAR_VAL = '0,
  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH),
  localparam int NLANES = (SIZE + BYTE_W - 1) / BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  output logic              busy,
  input  logic              rd_en,
  input  logic [AW-1:0]     raddr,
  output logic [SIZE-1:0]   read_data,
  output logic              rd_valid,
  input  logic              write_en,
  input  logic [AW-1:0]     waddr,
  input  logic [SIZE-1:0]   write_data,
  input  logic [NLANES-1:0] byte_en
);
  typedef enum logic {CLEAR, IDLE} state_t;
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  state_t state, state_nx;
  logic [AW-1:0] ptr;
  logic [SIZE-1:0] mem [DEPTH];
  logic [SIZE-1:0] mask, rdq, byp_d, byp_m;
  logic byp, wr, rd, rd_ok;
  assign busy = state == CLEAR;
  assign wr = !busy && write_en && ({1'b0, waddr} < DEPTH_V);
  assign rd = !busy && rd_en;
  assign rd_ok = {1'b0, raddr} < DEPTH_V;
  always_comb begin
    mask = '0;
    for (int i = 0; i < SIZE; i++) mask[i] = byte_en[i / BYTE_W];
  end
  always_comb state_nx = busy ? ((ptr == LAST) ? IDLE : CLEAR) : (clear ? CLEAR : IDLE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr <= '0;
    end else begin
      state <= state_nx;
      if (busy) ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end
  // Storage has no reset so it can map onto block RAM; the clear sequencer initialises it.
  always_ff @(posedge clk) begin
    if (busy) mem[ptr] <= CLEAR_VAL;
    else if (wr)
      for (int i = 0; i < SIZE; i++) if (mask[i]) mem[waddr][i] <= write_data[i];
  end
  // Write-first collisions are resolved by a registered bypass merged at the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rdq <= '0;
      byp <= 1'b0;
      byp_d <= '0;
      byp_m <= '0;
    end else begin
      rd_valid <= rd;
      if (rd) begin
        rdq <= rd_ok ? mem[raddr] : '0;
        byp <= (RD_MODE != 0) && wr && (raddr == waddr);
        byp_d <= write_data;
        byp_m <= mask;
      end
    end
  end
  assign read_data = byp ? ((byp_d & byp_m) | (rdq & ~byp_m)) : rdq;
endmodule
